// File: rtl/chrom_eval_initiator.sv
// Chromosome-evaluation initiator: it streams in a chromosome and runs the start/done/feedback handshake.
// It then reduces the returned error sums to one total and presents that total on a valid/ready port.
module chrom_eval_initiator #(
  parameter int SEG_COUNT      = 31,
  parameter int SEG_WIDTH      = 32,
  parameter int NUM_SUMS       = 8,
  parameter int SUM_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                            iClock,
  input  logic                            iReset,
  input  logic [SEG_WIDTH-1:0]            iSegData,
  input  logic                            iSegValid,
  output logic                            oSegReady,
  output logic [SEG_COUNT*SEG_WIDTH-1:0]  oConcatedChrom,
  output logic                            oStartProcessing,
  input  logic                            iReadyToProcess,
  input  logic                            iDoneProcessing,
  output logic                            oDoneProcessingFeedback,
  input  logic [NUM_SUMS*SUM_WIDTH-1:0]   iErrorSums,
  output logic [SUM_WIDTH+2:0]            oTotalError,
  output logic                            oResultValid,
  input  logic                            iResultReady,
  output logic                            oTimeout,
  output logic [2:0]                      oState
);

  typedef enum logic [2:0] {
    S_LOAD       = 3'd0,
    S_WAIT_READY = 3'd1,
    S_START      = 3'd2,
    S_FEEDBACK   = 3'd3,
    S_RELEASE    = 3'd4,
    S_SUM        = 3'd5,
    S_RESULT     = 3'd6
  } state_t;

  localparam int SEG_CNT_W = $clog2(SEG_COUNT);
  localparam int IDX_W     = (NUM_SUMS > 1) ? $clog2(NUM_SUMS) : 1;
  localparam int ACC_W     = SUM_WIDTH + 3;
  localparam int TMO_W     = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [SEG_CNT_W-1:0] SEG_LAST = SEG_CNT_W'(SEG_COUNT - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_SUMS - 1);
  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t                         r_state;
  logic [SEG_CNT_W-1:0]           r_seg_cnt;
  logic [SEG_COUNT*SEG_WIDTH-1:0] r_chrom;
  logic [SUM_WIDTH-1:0]           r_sums [NUM_SUMS];
  logic [IDX_W-1:0]               r_sum_idx;
  logic [ACC_W-1:0]               r_acc;
  logic [TMO_W-1:0]               r_tmo_cnt;
  logic                           r_timeout;
  logic                           w_tmo_hit;
  logic                           w_sum_latch;

  assign w_tmo_hit   = (r_tmo_cnt == TMO_LAST);
  assign w_sum_latch = (r_state == S_START) && iDoneProcessing;

  // Handshake outputs decode straight from the state register, so no input reaches an output combinationally.
  assign oSegReady               = (r_state == S_LOAD);
  assign oStartProcessing        = (r_state == S_START);
  assign oDoneProcessingFeedback = (r_state == S_FEEDBACK);
  assign oResultValid            = (r_state == S_RESULT);
  assign oConcatedChrom          = r_chrom;
  assign oTotalError             = r_acc;
  assign oTimeout                = r_timeout;
  assign oState                  = r_state;

  always_ff @(posedge iClock) begin
    if (w_sum_latch) begin
      for (int j = 0; j < NUM_SUMS; j++) begin
        r_sums[j] <= iErrorSums[j*SUM_WIDTH +: SUM_WIDTH];
      end
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_state   <= S_LOAD;
      r_seg_cnt <= '0;
      r_chrom   <= '0;
      r_sum_idx <= '0;
      r_acc     <= '0;
      r_tmo_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      // Outside the waiting states, and on every state change, the wait counter sits at zero.
      r_tmo_cnt <= '0;
      case (r_state)
        S_LOAD: begin
          if (iSegValid) begin
            r_chrom[r_seg_cnt*SEG_WIDTH +: SEG_WIDTH] <= iSegData;
            if (r_seg_cnt == '0) r_timeout <= 1'b0;
            if (r_seg_cnt == SEG_LAST) begin
              r_seg_cnt <= '0;
              r_state   <= S_WAIT_READY;
            end else begin
              r_seg_cnt <= r_seg_cnt + 1'b1;
            end
          end
        end
        S_WAIT_READY: begin
          if (iReadyToProcess) begin
            r_state <= S_START;
          end else if (w_tmo_hit) begin
            r_timeout <= 1'b1;
            r_seg_cnt <= '0;
            r_state   <= S_LOAD;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_START: begin
          if (iDoneProcessing) begin
            r_state <= S_FEEDBACK;
          end else if (w_tmo_hit) begin
            r_timeout <= 1'b1;
            r_seg_cnt <= '0;
            r_state   <= S_LOAD;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_FEEDBACK: begin
          if (!iDoneProcessing) begin
            r_state <= S_RELEASE;
          end else if (w_tmo_hit) begin
            r_timeout <= 1'b1;
            r_seg_cnt <= '0;
            r_state   <= S_LOAD;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          r_acc     <= '0;
          r_sum_idx <= '0;
          r_state   <= S_SUM;
        end
        S_SUM: begin
          // The three guard bits absorb eight full-scale sums, so the total cannot wrap.
          r_acc     <= r_acc + ACC_W'(r_sums[r_sum_idx]);
          r_sum_idx <= r_sum_idx + 1'b1;
          if (r_sum_idx == IDX_LAST) r_state <= S_RESULT;
        end
        S_RESULT: begin
          if (iResultReady) r_state <= S_LOAD;
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule
